reg_file_arbiter: RTL and testbench

REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_rr_arb.sv | 18 +
 rtl/reg_file_arbiter.sv | 130 +++++++++++++
 tb/tb_reg_file_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
package reg_file_pkg;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_ADDR_WIDTH    = 3;
    localparam int DEF_RF_ADDR_WIDTH = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CMD  = 2'd1;
    localparam state_t RESP = 2'd2;

endpackage

// File: rtl/reg_file_rr_arb.sv
// Two-way tie-break: a lone request wins outright, a tie goes to the pointer.
module reg_file_rr_arb
    import reg_file_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    output logic       winner
);

    always_comb begin
        if (req == 2'b11) begin
            winner = pointer;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Arbitrates two requesters onto a single register-file port (IDLE -> CMD -> RESP).
// Define RF_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to requester 0.
module reg_file_arbiter
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int RF_ADDR_WIDTH = DEF_RF_ADDR_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req0,
    input  logic                     op0,
    input  logic [ADDR_WIDTH-1:0]    addr0,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    output logic                     ack0,
    input  logic                     req1,
    input  logic                     op1,
    input  logic [ADDR_WIDTH-1:0]    addr1,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     ack1,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     busy,
    output logic                     gnt_id,
    output logic                     rf_wr_en,
    output logic                     rf_rd_en,
    output logic [RF_ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0]    rf_wr_data,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data
);

    state_t                  state;
    logic                    lat_op;
    logic                    winner;
    logic                    arb_pointer;
    logic                    win_op;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    // Pointer names the requester that was not served last.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && (req0 || req1)) begin
            rr_ptr <= ~winner;
        end
    end

    assign arb_pointer = rr_ptr;
`else
    assign arb_pointer = 1'b0;
`endif

    reg_file_rr_arb u_arb (
        .req     ({req1, req0}),
        .pointer (arb_pointer),
        .winner  (winner)
    );

    always_comb begin
        win_op    = winner ? op1    : op0;
        win_addr  = winner ? addr1  : addr0;
        win_wdata = winner ? wdata1 : wdata0;
    end

    // rf_address/rf_wr_data double as the latched copy, so requester inputs
    // are never looked at again after the grant edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            lat_op     <= OP_READ;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            gnt_id     <= 1'b0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_address <= '0;
            rf_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state      <= CMD;
                        busy       <= 1'b1;
                        gnt_id     <= winner;
                        lat_op     <= win_op;
                        rf_wr_en   <= (win_op == OP_WRITE);
                        rf_rd_en   <= (win_op == OP_READ);
                        rf_address <= RF_ADDR_WIDTH'(win_addr);
                        rf_wr_data <= win_wdata;
                    end
                end
                CMD: begin
                    state    <= RESP;
                    rf_wr_en <= 1'b0;
                    rf_rd_en <= 1'b0;
                    ack0     <= ~gnt_id;
                    ack1     <= gnt_id;
                end
                RESP: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    busy     <= 1'b0;
                    rf_wr_en <= 1'b0;
                    rf_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Register file returns read data during RESP, so rd_data is steered combinationally.
    always_comb begin
        rd_data = '0;
        if (state == RESP && lat_op == OP_READ) begin
            rd_data = rf_rd_data;
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter: vector table, corner sequences, randomized traffic vs. a transaction model.
module tb_reg_file_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
    logic [2:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, gnt_id, rf_wr_en, rf_rd_en;
    logic [15:0] rd_data, rf_wr_data;
    logic [15:0] rf_rd_data = '0;
    logic [7:0]  rf_address;

    reg_file_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .RF_ADDR_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rd_data(rd_data), .busy(busy), .gnt_id(gnt_id),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_address(rf_address),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data)
    );

    always #5 CLK = ~CLK;

    // Register file attached to the arbiter: registered read, one-cycle latency.
    logic [15:0] rf_mem [256];
    always @(posedge CLK) begin
        if (rf_wr_en) rf_mem[rf_address] <= rf_wr_data;
        if (rf_rd_en) rf_rd_data <= rf_mem[rf_address];
    end

    typedef struct {
        logic        r0, o0; logic [2:0] a0; logic [15:0] d0;
        logic        r1, o1; logic [2:0] a1; logic [15:0] d1;
        logic        exp_first;
        logic [15:0] exp_rd0, exp_rd1;
    } vec_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [15:0] mem [8];     // reference contents of the addressable entries
    logic        last;        // requester served most recently (1 right after reset)

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            chk("rf_en_exclusive", {63'd0, rf_wr_en & rf_rd_en}, 64'd0);
            chk("ack_exclusive", {63'd0, ack0 & ack1}, 64'd0);
        end
    end

    function automatic logic model_pick(input logic p0, input logic p1);
        if (p0 && p1) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
            return ~last;
`else
            return 1'b0;
`endif
        end
        return p1;
    endfunction

    task automatic do_reset();
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        RST = 0;
        #1;
        chk("reset_state", {ack0, ack1, busy, gnt_id, rf_wr_en, rf_rd_en, rf_address, rf_wr_data, rd_data}, 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1;
        last = 1'b1;
    endtask

    // Applies one request pattern; each requester holds until acked, then drops.
    task automatic do_txn(input vec_t v, input bit perturb,
                          output logic [15:0] rd0, output logic [15:0] rd1, output logic first);
        logic p0, p1, w, wop;
        logic [2:0]  wa;
        logic [15:0] wd, exp_rd;
        rd0 = '0; rd1 = '0; first = 1'b0;
        p0 = v.r0; p1 = v.r1;
        req0 = v.r0; op0 = v.o0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; op1 = v.o1; addr1 = v.a1; wdata1 = v.d1;
        for (int k = 0; k < 2; k++) begin
            if (p0 || p1) begin
                w   = model_pick(p0, p1);
                if (k == 0) first = w;
                wop = w ? v.o1 : v.o0;
                wa  = w ? v.a1 : v.a0;
                wd  = w ? v.d1 : v.d0;
                @(posedge CLK); #1;
                chk("cmd_busy", busy, 1);
                chk("cmd_gnt_id", gnt_id, w);
                chk("cmd_wr_en", rf_wr_en, wop);
                chk("cmd_rd_en", rf_rd_en, !wop);
                chk("cmd_address", rf_address, {5'd0, wa});
                chk("cmd_wr_data", rf_wr_data, wd);
                chk("cmd_ack", {ack1, ack0}, 0);
                if (perturb) begin
                    if (w) begin addr1 = 3'($urandom); wdata1 = 16'($urandom); op1 = ~op1; end
                    else   begin addr0 = 3'($urandom); wdata0 = 16'($urandom); op0 = ~op0; end
                end
                @(posedge CLK); #1;
                exp_rd = wop ? 16'h0 : mem[wa];
                if (wop) mem[wa] = wd;
                chk("resp_ack", {ack1, ack0}, w ? 2'b10 : 2'b01);
                chk("resp_rd_data", rd_data, exp_rd);
                chk("resp_rf_en", {rf_wr_en, rf_rd_en}, 0);
                chk("resp_busy", busy, 1);
                if (w) begin rd1 = rd_data; p1 = 0; req1 = 0; end
                else   begin rd0 = rd_data; p0 = 0; req0 = 0; end
                last = w;
                @(posedge CLK); #1;
                chk("idle_ack", {ack1, ack0}, 0);
                chk("idle_busy", busy, 0);
            end
        end
    endtask

    vec_t        vecs [6];
    vec_t        rv;
    logic [15:0] g0, g1;
    logic        gf;
    logic [5:0]  gseq;
    logic [5:0]  exp_seq;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rf_mem[i] = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        last = 1'b1;

        //             r0 o0 a0  d0        r1 o1 a1  d1        first rd0       rd1
        vecs[0] = '{1, 1, 5, 16'hFFFF, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[1] = '{0, 0, 0, 16'h0000, 1, 0, 5, 16'h0000, 1, 16'h0000, 16'hFFFF};
        vecs[2] = '{1, 1, 0, 16'hE38A, 1, 1, 1, 16'h00FF, 0, 16'h0000, 16'h0000};
        vecs[3] = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'hE38A, 16'h0000};
        vecs[4] = '{0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 1, 16'h0000, 16'h00FF};
        vecs[5] = '{1, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 0, 16'hE38A, 16'h00FF};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i], 1'b0, g0, g1, gf);
            chk($sformatf("vec%0d_first", i), gf, vecs[i].exp_first);
            chk($sformatf("vec%0d_rd0", i), g0, vecs[i].exp_rd0);
            chk($sformatf("vec%0d_rd1", i), g1, vecs[i].exp_rd1);
        end

        // Held simultaneous reads: grant order over six transactions.
        do_reset();
        req0 = 1; op0 = 0; addr0 = 0; req1 = 1; op1 = 0; addr1 = 1;
        gseq = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            chk("held_gnt_id", gnt_id, model_pick(1'b1, 1'b1));
            gseq[k] = gnt_id;
            @(posedge CLK); #1;
            chk("held_rd_data", rd_data, gnt_id ? mem[1] : mem[0]);
            last = gnt_id;
            @(posedge CLK); #1;
        end
        req0 = 0; req1 = 0;
`ifdef RF_ARB_ROUND_ROBIN_EN
        exp_seq = 6'b101010;
`else
        exp_seq = 6'b000000;
`endif
        chk("held_grant_sequence", gseq, exp_seq);

        // Reset pulsed during CMD of a write.
        req0 = 1; op0 = 1; addr0 = 2; wdata0 = 16'h5A5A;
        @(posedge CLK); #1;
        chk("abort_cmd_wr_en", rf_wr_en, 1);
        RST = 0;
        #1;
        chk("abort_outputs", {ack0, ack1, busy, gnt_id, rf_wr_en, rf_rd_en, rf_address, rf_wr_data, rd_data}, 64'd0);
        @(negedge CLK);
        req0 = 0;
        RST = 1;
        last = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("abort_no_ack", {ack1, ack0, busy}, 0);
        end
        do_txn('{1, 1, 2, 16'h1111, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0}, 1'b0, g0, g1, gf);
        do_txn('{0, 0, 0, 16'h0, 1, 0, 2, 16'h0, 1, 16'h0, 16'h0}, 1'b0, g0, g1, gf);
        chk("after_abort_readback", g1, 16'h1111);

        // Requester inputs changed mid-transaction must not reach the register file.
        do_txn('{1, 1, 3, 16'h1234, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0}, 1'b1, g0, g1, gf);
        do_txn('{1, 0, 3, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0}, 1'b0, g0, g1, gf);
        chk("perturb_readback", g0, 16'h1234);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            rv.r0 = 1'($urandom); rv.r1 = 1'($urandom);
            if (!rv.r0 && !rv.r1) rv.r0 = 1'b1;
            rv.o0 = 1'($urandom); rv.a0 = 3'($urandom); rv.d0 = 16'($urandom);
            rv.o1 = 1'($urandom); rv.a1 = 3'($urandom); rv.d1 = 16'($urandom);
            rv.exp_first = 1'b0; rv.exp_rd0 = '0; rv.exp_rd1 = '0;
            do_txn(rv, 1'($urandom), g0, g1, gf);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
                chk("gap_busy", busy, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
